audio_frame_loader: RTL and testbench
=====================================

# audio_frame_loader

Collects the incoming audio sample stream into fixed-length frames and presents each complete frame to the FFT core's AXI-Stream data input (`s_axis_data_*`) as FRAME_LEN complex beats, with `tlast` on the final beat. The loader sits directly upstream of the FFT. It ping-pongs between two frame banks so that sample capture continues while the previous frame streams out, and it flags any sample it has to drop.

## Interface
- SAMPLE_WIDTH, 16, bit width of a real audio sample (two's complement).
- FRAME_LEN, 1024, samples per frame. Power of two, ≥ 4. Must equal the FFT transform length.
- clk_in  input  1  system clock (100 MHz); all logic is in this single domain.
- rst_in  input  1  reset, synchronous and active-high.
- audio_valid_in  input  1  single-cycle strobe: audio_sample_in is valid this cycle.
- audio_sample_in  input  SAMPLE_WIDTH  signed audio sample.
- m_axis_tdata  output  2*SAMPLE_WIDTH  beat data: {imag, real} = {SAMPLE_WIDTH'b0, sample}.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tlast  output  1  high on beat FRAME_LEN-1 of each frame.
- m_axis_tready  input  1  FFT ready.
- overrun_out  output  1  one-cycle pulse when an incoming sample is dropped.
- frames_sent_out  output  16  count of frames fully accepted downstream. Wraps at 2^16.

## Operation
- Storage: two banks of FRAME_LEN × SAMPLE_WIDTH, inferred as dual-port BRAM with a 1-cycle read latency. Each bank has a `full` flag.
- Writer state: wr_bank, wr_idx (log2 FRAME_LEN bits).
- On audio_valid_in with full[wr_bank]=0: store the sample at wr_idx and increment wr_idx.
  - If wr_idx was FRAME_LEN-1: set full[wr_bank], set wr_idx to 0, toggle wr_bank.
- On audio_valid_in with full[wr_bank]=1: drop the sample, pulse overrun_out next cycle, leave wr_idx unchanged.
- Reader FSM has two states:
  - IDLE → STREAM when full[rd_bank]=1.
  - STREAM issues BRAM reads for rd_bank indices 0..FRAME_LEN-1 into a 2-entry skid buffer feeding the output register.
  - STREAM → IDLE on the handshake (tvalid & tready) of the tlast beat. On that handshake: clear full[rd_bank], toggle rd_bank, increment frames_sent_out.
  - If the other bank is already full, return to STREAM on the following cycle.
- Flag updates within a cycle: the writer tests full[] using its pre-update value. A sample that arrives in the same cycle its bank is being cleared is dropped, with an overrun.
- Output data: real = the stored sample bit-for-bit (no sign extension into imag); imag = 0.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overrun_out=0, frames_sent_out=0; full[1:0]=0, wr_bank=rd_bank=0, wr_idx=0, FSM=IDLE.
- Reset mid-operation: on the next cycle tvalid is 0 and all partial or complete frames are discarded. No tlast is emitted for the interrupted frame.
- Latency: m_axis_tvalid rises at the 3rd rising edge after the edge that writes a frame's final sample, provided the reader was IDLE.
- AXI-S rules:
  - While tvalid=1 and tready=0, tdata and tlast hold stable.
  - tvalid never drops before the tlast beat is accepted. There are no bubbles inside a frame, whatever the tready pattern.
- Throughput: one beat per cycle while tready=1. A FRAME_LEN frame drains in FRAME_LEN cycles.
- Between frames: at least 1 cycle with tvalid=0 after a tlast handshake.
- tready has no combinational path to tdata or tvalid. The skid buffer absorbs the 1-cycle BRAM latency.

## Test plan
- FRAME_LEN=8, samples 0..7 on consecutive cycles, tready=1.
  - Required: 8 beats with tdata 0x0000_0000..0x0000_0007 and tlast only on 0x0000_0007.
  - Required: tvalid rises 3 edges after sample 7 is written; frames_sent_out=1.
- Sample value 16'h8000.
  - Required: tdata=32'h0000_8000 (imag stays zero).
- Backpressure: toggle tready pseudo-randomly during a frame.
  - Required: every beat is delivered exactly once, in order.
  - Required: tdata and tlast stay stable while stalled; tvalid stays high until the tlast handshake.
- Overrun: FRAME_LEN=8, tready=0, write 17 samples.
  - Required: both banks full after 16 samples; sample 17 dropped with one overrun_out pulse.
  - Then raise tready: frames 0..7 and 8..15 are emitted back-to-back, and frames_sent_out=2.
- Continuous audio: one sample every 4 cycles for 5 frames, tready=1.
  - Required: no overrun, and 5 frames in sample order.
- Reset mid-stream: assert rst_in for 1 cycle on beat 3 of a frame.
  - Required: tvalid=0 the next cycle and counters=0.
  - Required: the next 8 samples form a clean frame starting at index 0.

Source files
------------

// File: rtl/audio_frame_loader.sv
// =============================================================================
// audio_frame_loader : ping-pong frame capture feeding the FFT AXI-Stream input
// Rev 1.0
// =============================================================================
`default_nettype none

module audio_frame_loader #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FRAME_LEN    = 1024
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      audio_valid_in,
   input  logic [SAMPLE_WIDTH-1:0]   audio_sample_in,
   output logic [2*SAMPLE_WIDTH-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic                      overrun_out,
   output logic [15:0]               frames_sent_out
);

   localparam int              c_aw       = $clog2(FRAME_LEN);
   localparam logic [c_aw-1:0] c_last_idx = c_aw'(FRAME_LEN - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              full_q, full_d;
   logic                    wr_bank_q, wr_bank_d;
   logic [c_aw-1:0]         wr_idx_q, wr_idx_d;
   logic                    rd_bank_q, rd_bank_d;
   logic [c_aw-1:0]         rd_addr_q, rd_addr_d;
   logic                    issue_done_q, issue_done_d;
   logic                    overrun_q;
   logic [15:0]             frames_q, frames_d;

   logic [SAMPLE_WIDTH-1:0] mem_q [2*FRAME_LEN];
   logic [SAMPLE_WIDTH-1:0] rd_data_q;
   logic                    rd_vld_q, rd_last_q;

   logic [SAMPLE_WIDTH-1:0] skid_data_q [2];
   logic [SAMPLE_WIDTH-1:0] skid_data_d [2];
   logic [1:0]              skid_last_q, skid_last_d;
   logic [1:0]              skid_cnt_q, skid_cnt_d;

   logic                    out_vld_q, out_vld_d;
   logic                    out_last_q, out_last_d;
   logic [SAMPLE_WIDTH-1:0] out_data_q, out_data_d;

   logic                    w_wr_en, w_wr_wrap, w_last_hs, w_rd_issue;
   logic                    w_out_free, w_skid_pop, w_skid_push;
   logic [1:0]              w_cnt_after_pop;

   // Writer sees the pre-update full flag, so a bank cleared this cycle still drops.
   assign w_wr_en   = audio_valid_in & ~full_q[wr_bank_q];
   assign w_wr_wrap = w_wr_en & (wr_idx_q == c_last_idx);
   assign w_last_hs = out_vld_q & m_axis_tready & out_last_q;

   always_comb begin : p_flags
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      full_d    = full_q;
      frames_d  = frames_q;
      if (w_wr_en) begin
         wr_idx_d = wr_idx_q + c_aw'(1);
      end
      if (w_wr_wrap) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
      if (w_last_hs) begin
         full_d[rd_bank_q] = 1'b0;
         frames_d          = frames_q + 16'd1;
      end
   end

   always_comb begin : p_fsm
      state_d      = state_q;
      rd_bank_d    = rd_bank_q;
      rd_addr_d    = rd_addr_q;
      issue_done_d = issue_done_q;
      w_rd_issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rd_addr_d    = '0;
            issue_done_d = 1'b0;
            if (full_q[rd_bank_q]) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // Only issue a read if the skid buffer can absorb it even under a full stall.
            w_rd_issue = ~issue_done_q &
                         ((skid_cnt_q == 2'd0) | ((skid_cnt_q == 2'd1) & ~rd_vld_q));
            if (w_rd_issue) begin
               rd_addr_d = rd_addr_q + c_aw'(1);
               if (rd_addr_q == c_last_idx) begin
                  issue_done_d = 1'b1;
               end
            end
            if (w_last_hs) begin
               state_d   = ST_IDLE;
               rd_bank_d = ~rd_bank_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin : p_out_next
      out_vld_d       = out_vld_q;
      out_last_d      = out_last_q;
      out_data_d      = out_data_q;
      skid_data_d     = skid_data_q;
      skid_last_d     = skid_last_q;
      w_out_free      = ~out_vld_q | m_axis_tready;
      w_skid_pop      = w_out_free & (skid_cnt_q != 2'd0);
      w_skid_push     = rd_vld_q & ~(w_out_free & (skid_cnt_q == 2'd0));
      w_cnt_after_pop = skid_cnt_q - 2'(w_skid_pop);
      if (w_out_free) begin
         if (skid_cnt_q != 2'd0) begin
            out_vld_d  = 1'b1;
            out_data_d = skid_data_q[0];
            out_last_d = skid_last_q[0];
         end else if (rd_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = rd_data_q;
            out_last_d = rd_last_q;
         end else begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
         end
      end
      if (w_skid_pop) begin
         skid_data_d[0] = skid_data_q[1];
         skid_last_d[0] = skid_last_q[1];
      end
      if (w_skid_push) begin
         skid_data_d[w_cnt_after_pop[0]] = rd_data_q;
         skid_last_d[w_cnt_after_pop[0]] = rd_last_q;
      end
      skid_cnt_d = w_cnt_after_pop + 2'(w_skid_push);
   end

   always_ff @(posedge clk_in) begin : p_regs
      if (rst_in) begin
         state_q      <= ST_IDLE;
         full_q       <= '0;
         wr_bank_q    <= 1'b0;
         wr_idx_q     <= '0;
         rd_bank_q    <= 1'b0;
         rd_addr_q    <= '0;
         issue_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         frames_q     <= '0;
         rd_vld_q     <= 1'b0;
         rd_last_q    <= 1'b0;
         skid_cnt_q   <= '0;
         skid_last_q  <= '0;
         out_vld_q    <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         full_q       <= full_d;
         wr_bank_q    <= wr_bank_d;
         wr_idx_q     <= wr_idx_d;
         rd_bank_q    <= rd_bank_d;
         rd_addr_q    <= rd_addr_d;
         issue_done_q <= issue_done_d;
         overrun_q    <= audio_valid_in & full_q[wr_bank_q];
         frames_q     <= frames_d;
         rd_vld_q     <= w_rd_issue;
         rd_last_q    <= w_rd_issue & (rd_addr_q == c_last_idx);
         skid_cnt_q   <= skid_cnt_d;
         skid_last_q  <= skid_last_d;
         out_vld_q    <= out_vld_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
      end
   end

   always_ff @(posedge clk_in) begin : p_mem
      if (w_wr_en) begin
         mem_q[{wr_bank_q, wr_idx_q}] <= audio_sample_in;
      end
      rd_data_q <= mem_q[{rd_bank_q, rd_addr_q}];
   end

   always_ff @(posedge clk_in) begin : p_skid_data
      skid_data_q <= skid_data_d;
   end

   assign m_axis_tdata    = {{SAMPLE_WIDTH{1'b0}}, out_data_q};
   assign m_axis_tvalid   = out_vld_q;
   assign m_axis_tlast    = out_last_q;
   assign overrun_out     = overrun_q;
   assign frames_sent_out = frames_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_frame_loader.sv
// =============================================================================
// tb_audio_frame_loader : scoreboard bench for audio_frame_loader (FRAME_LEN=8)
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_audio_frame_loader;

   localparam int FL = 8;

   logic        clk;
   logic        rst_in;
   logic        audio_valid_in;
   logic [15:0] audio_sample_in;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        overrun_out;
   logic [15:0] frames_sent_out;

   audio_frame_loader #(
      .SAMPLE_WIDTH (16),
      .FRAME_LEN    (FL)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .audio_valid_in  (audio_valid_in),
      .audio_sample_in (audio_sample_in),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready),
      .overrun_out     (overrun_out),
      .frames_sent_out (frames_sent_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference model: frames as plain sample lists ----------------
   logic [16:0] exp_q [$];
   int          lat_q [$];
   int          ovr_q [$];
   logic [15:0] cur_q [$];
   int          outstanding = 0;
   int          p_before;

   always @(negedge clk) begin : p_predict
      if (rst_in) begin
         exp_q.delete();
         lat_q.delete();
         ovr_q.delete();
         cur_q.delete();
         outstanding = 0;
      end else begin
         p_before = outstanding;
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast && outstanding > 0)
            outstanding--;
         if (audio_valid_in) begin
            if (p_before == 2) begin
               ovr_q.push_back(cyc + 1);
            end else begin
               cur_q.push_back(audio_sample_in);
               if (cur_q.size() == FL) begin
                  for (int i = 0; i < FL; i++)
                     exp_q.push_back({(i == FL - 1), cur_q[i]});
                  if (p_before == 0)
                     lat_q.push_back(cyc + 4);
                  cur_q.delete();
                  outstanding++;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   logic        mon_prev_rst   = 1'b1;
   logic        mon_prev_valid = 1'b0;
   logic        mon_prev_ready = 1'b0;
   logic        mon_prev_last  = 1'b0;
   logic [31:0] mon_prev_data  = '0;
   logic        mon_frames_chk = 1'b0;
   logic [15:0] mon_frames     = '0;
   logic [16:0] mon_e;
   logic        mon_oexp;

   always @(negedge clk) begin : p_monitor
      if (rst_in) begin
         mon_prev_rst   = 1'b1;
         mon_prev_valid = 1'b0;
         mon_prev_ready = 1'b0;
         mon_prev_last  = 1'b0;
         mon_frames_chk = 1'b0;
         mon_frames     = '0;
      end else begin
         if (mon_prev_rst) begin
            chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("reset_frames", 32'(frames_sent_out), 32'd0);
         end
         if (mon_prev_valid && !mon_prev_ready) begin
            chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("stall_tdata", m_axis_tdata, mon_prev_data);
            chk("stall_tlast", 32'(m_axis_tlast), 32'(mon_prev_last));
         end
         if (mon_prev_valid && mon_prev_ready)
            chk(mon_prev_last ? "gap_after_tlast" : "no_bubble",
                32'(m_axis_tvalid), 32'(!mon_prev_last));
         if (mon_frames_chk)
            chk("frames_sent", 32'(frames_sent_out), 32'(mon_frames));
         mon_frames_chk = 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: actual tdata=0x%0h required no beat (cycle %0d)",
                        m_axis_tdata, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat_tdata", m_axis_tdata, {16'h0000, mon_e[15:0]});
               chk("beat_tlast", 32'(m_axis_tlast), 32'(mon_e[16]));
            end
            if (m_axis_tlast) begin
               mon_frames     = mon_frames + 16'd1;
               mon_frames_chk = 1'b1;
            end
         end
         mon_oexp = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
         if (mon_oexp || overrun_out)
            chk("overrun_pulse", 32'(overrun_out), 32'(mon_oexp));
         if (mon_oexp)
            void'(ovr_q.pop_front());
         if (lat_q.size() > 0 && lat_q[0] == cyc) begin
            chk("latency_rise", {30'd0, mon_prev_valid, m_axis_tvalid}, 32'd1);
            void'(lat_q.pop_front());
         end
         mon_prev_valid = m_axis_tvalid;
         mon_prev_ready = m_axis_tready;
         mon_prev_last  = m_axis_tlast;
         mon_prev_data  = m_axis_tdata;
         mon_prev_rst   = 1'b0;
      end
   end

   // ---------------- tready generator: 0 = stall, 1 = ready, 2 = random ----------------
   int ready_mode = 1;

   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [15:0] s);
      audio_valid_in  = 1'b1;
      audio_sample_in = s;
      @(posedge clk);
      #1;
      audio_valid_in  = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_remaining_beats", 32'(exp_q.size()), 32'd0);
      idle(3);
   endtask

   initial begin
      int n;
      rst_in          = 1'b1;
      audio_valid_in  = 1'b0;
      audio_sample_in = '0;
      idle(3);
      rst_in = 1'b0;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
      chk("rst_tdata", m_axis_tdata, 32'd0);
      chk("rst_overrun", 32'(overrun_out), 32'd0);
      chk("rst_frames", 32'(frames_sent_out), 32'd0);

      // Ramp frame 0..7, always ready
      ready_mode = 1;
      idle(2);
      for (int i = 0; i < FL; i++) send(16'(i));
      wait_drain(100);
      chk("frames_after_ramp", 32'(frames_sent_out), 32'd1);

      // Sign-bit boundary values must not leak into imag
      send(16'h8000);
      send(16'h7fff);
      send(16'hffff);
      send(16'h0001);
      for (int i = 0; i < 4; i++) send(16'($urandom));
      wait_drain(100);
      chk("frames_after_sign", 32'(frames_sent_out), 32'd2);

      // Random backpressure with random sample gaps
      ready_mode = 2;
      for (int i = 0; i < 2 * FL; i++) begin
         send(16'($urandom));
         idle($urandom_range(0, 2));
      end
      wait_drain(500);
      ready_mode = 1;
      idle(2);
      chk("frames_after_bp", 32'(frames_sent_out), 32'd4);

      // Overrun: both banks fill while stalled, 17th sample dropped
      ready_mode = 0;
      idle(2);
      for (int i = 0; i < 2 * FL + 1; i++) send(16'h0100 + 16'(i));
      idle(10);
      chk("stalled_tvalid", 32'(m_axis_tvalid), 32'd1);
      ready_mode = 1;
      wait_drain(200);
      chk("frames_after_overrun", 32'(frames_sent_out), 32'd6);

      // Continuous audio, one sample every 4 cycles for 5 frames
      for (int i = 0; i < 5 * FL; i++) begin
         send(16'($urandom));
         idle(3);
      end
      wait_drain(200);
      chk("frames_after_continuous", 32'(frames_sent_out), 32'd11);

      // Reset while beat 3 of a frame is presented
      for (int i = 0; i < FL; i++) send(16'h1000 + 16'(i));
      n = 0;
      while (!(m_axis_tvalid && m_axis_tdata == 32'h0000_1003) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("beat3_presented", m_axis_tdata, 32'h0000_1003);
      rst_in = 1'b1;
      idle(1);
      rst_in = 1'b0;
      chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("midrst_frames", 32'(frames_sent_out), 32'd0);
      idle(2);
      for (int i = 0; i < FL; i++) send(16'h2000 + 16'(i));
      wait_drain(100);
      chk("frames_after_midrst", 32'(frames_sent_out), 32'd1);

      idle(5);
      chk("pending_latency_checks", 32'(lat_q.size()), 32'd0);
      chk("pending_overrun_checks", 32'(ovr_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
